stream2rgb: RTL and testbench
=============================

STREAM2RGB -- requirements
Module: stream2rgb

Interface
REQ-001 Parameter PIXEL_WIDTH, default 10, bits per colour channel.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 dvi  input  1  input word valid.
REQ-005 dtypei  input  `DTYPE_WIDTH  input data type (dtypes.v encodings).
REQ-006 datai  input  32  packed input word.
REQ-007 rdyo  output  1  ready; a word transfers only when dvi and rdyo are both high.
REQ-008 dvo  output  1  output valid, registered.
REQ-009 dtypeo  output  `DTYPE_WIDTH  output data type, registered.
REQ-010 r, g, b  output  PIXEL_WIDTH each  unpacked pixel channels, registered.
REQ-011 meta_datao  output  16  header half-word, registered.

Function
REQ-012 Input bitstream is MSB-first contiguous; each pixel occupies 3*PIXEL_WIDTH bits ordered {r,g,b}, r most significant; pixels may straddle word boundaries.
REQ-013 Internal accumulator ibuf is 32+3*PIXEL_WIDTH bits; ipos is the count of valid unconsumed bits, 7 bits wide.
REQ-014 rdyo = (ipos < 3*PIXEL_WIDTH) and state != HDR_HI, combinational from registered state only.
REQ-015 Pixel word accepted (dvi, rdyo, dtypei & `DTYPE_PIXEL_MASK nonzero): ibuf <= {ibuf, datai} truncated to width; ipos <= ipos+32; latched pixel dtype <= dtypei; dvo <= 0.
REQ-016 Emit cycle (ipos >= 3*PIXEL_WIDTH): {r,g,b} <= bits [ipos-1 : ipos-3*PIXEL_WIDTH] of ibuf; ipos <= ipos-3*PIXEL_WIDTH; dvo <= 1; dtypeo <= latched pixel dtype.
REQ-017 Accept and emit never coincide (guaranteed by REQ-014); one pixel max per cycle; emit latency one cycle after ipos reaches threshold.
REQ-018 FRAME_START or HEADER_START accepted: ipos <= 0 (residual bits discarded); dvo <= 1; dtypeo <= dtypei; r,g,b unchanged.
REQ-019 States: IDLE, HDR_HI. HEADER word accepted in IDLE: meta_datao <= datai[15:0], dvo <= 1, dtypeo <= HEADER, hold datai[31:16], go HDR_HI.
REQ-020 HDR_HI: meta_datao <= held upper half, dvo <= 1, dtypeo <= HEADER, rdyo low, return to IDLE next cycle.
REQ-021 Any other accepted dtype (e.g. FRAME_END): ipos <= 0; dvo <= 1; dtypeo <= dtypei; meta_datao <= 0.
REQ-022 No acceptance and no emit: dvo <= 0; dtypeo, r, g, b, meta_datao hold.
REQ-023 dvi high while rdyo low: word is not consumed; upstream holds datai/dtypei stable until rdyo.
REQ-024 Residual bits below 3*PIXEL_WIDTH at frame end are discarded by the next non-pixel accept, never emitted.
REQ-025 ipos never exceeds 3*PIXEL_WIDTH+31; ibuf bits above ipos are don't-care.

Reset
REQ-026 reset high at a clock edge: dvo=0, dtypeo=0, r=g=b=0, meta_datao=0, ipos=0, state=IDLE, latched dtype=0; applies mid-frame and mid-header, discarding partial data.
REQ-027 rdyo is 1 in the first cycle after reset deasserts.

Verification
REQ-028 PIXEL_WIDTH=10: FRAME_START, then 15 pixel words packing 16 pixels r=n, g=0x3FF-n, b=0x155^n (n=0..15) -> exactly 16 dvo pulses with matching r,g,b in order, then FRAME_END -> dvo=1, dtypeo=FRAME_END.
REQ-029 HEADER word 0x12345678 -> meta_datao=0x5678 then 0x1234 on consecutive dvo cycles, dtypeo=HEADER; rdyo=0 during second cycle.
REQ-030 dvi held high continuously over pixel words -> rdyo toggles; no word lost or duplicated; pixel stream bit-exact vs model.
REQ-031 Three pixel words (96 bits, 3 pixels + 6 residual bits) then FRAME_START -> 3 pixels out; residual dropped; ipos=0 afterwards.
REQ-032 reset asserted one cycle after second pixel word -> next cycle all outputs 0, rdyo=1; next frame unpacks correctly from bit 0.
REQ-033 PIXEL_WIDTH=8: 3 words carry 4 pixels (0x112233, 0x445566, 0x778899, 0xAABBCC) -> four pixels emitted in order.

Source files
------------

// File: rtl/stream2rgb.sv
// Unpacks an MSB-first contiguous bitstream of {r,g,b} pixels from 32-bit words,
// and passes frame/header control words through with their payload.
`ifndef DTYPE_WIDTH
`define DTYPE_WIDTH        8
`define DTYPE_FRAME_START  8'h01
`define DTYPE_FRAME_END    8'h02
`define DTYPE_HEADER_START 8'h04
`define DTYPE_HEADER       8'h08
`define DTYPE_PIXEL_MASK   8'hF0
`endif

module stream2rgb #(
  parameter int PIXEL_WIDTH = 10
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    dvi,
  input  logic [`DTYPE_WIDTH-1:0] dtypei,
  input  logic [31:0]             datai,
  output logic                    rdyo,
  output logic                    dvo,
  output logic [`DTYPE_WIDTH-1:0] dtypeo,
  output logic [PIXEL_WIDTH-1:0]  r,
  output logic [PIXEL_WIDTH-1:0]  g,
  output logic [PIXEL_WIDTH-1:0]  b,
  output logic [15:0]             meta_datao
);
  localparam int PW3 = 3 * PIXEL_WIDTH;
  localparam int BW  = 32 + PW3;
  localparam logic [6:0] PW3_7 = 7'(PW3);

  typedef enum logic {IDLE, HDR_HI} state_t;

  state_t                  state, state_d;
  logic [BW-1:0]           ibuf;
  logic [6:0]              ipos;
  logic [`DTYPE_WIDTH-1:0] pix_dtype;
  logic [15:0]             hold_hi;
  logic [BW-1:0]           shifted;
  logic [PW3-1:0]          pix;
  logic                    accept, emit, is_pix, is_start, is_hdr;

  assign rdyo     = (ipos < PW3_7) && (state != HDR_HI);
  assign accept   = dvi && rdyo;
  assign emit     = (state == IDLE) && (ipos >= PW3_7);
  assign is_pix   = (dtypei & `DTYPE_PIXEL_MASK) != '0;
  assign is_start = (dtypei == `DTYPE_FRAME_START) || (dtypei == `DTYPE_HEADER_START);
  assign is_hdr   = (dtypei == `DTYPE_HEADER);
  // The oldest unconsumed pixel sits just below ipos.
  assign shifted  = ibuf >> (ipos - PW3_7);
  assign pix      = shifted[PW3-1:0];

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (accept && !is_pix && !is_start && is_hdr) state_d = HDR_HI;
      HDR_HI:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ibuf       <= '0;
      ipos       <= '0;
      pix_dtype  <= '0;
      hold_hi    <= '0;
      dvo        <= 1'b0;
      dtypeo     <= '0;
      r          <= '0;
      g          <= '0;
      b          <= '0;
      meta_datao <= '0;
    end else if (state == HDR_HI) begin
      meta_datao <= hold_hi;
      dvo        <= 1'b1;
      dtypeo     <= `DTYPE_HEADER;
    end else if (emit) begin
      {r, g, b} <= pix;
      ipos      <= ipos - PW3_7;
      dvo       <= 1'b1;
      dtypeo    <= pix_dtype;
    end else if (accept) begin
      if (is_pix) begin
        ibuf      <= {ibuf[BW-33:0], datai};
        ipos      <= ipos + 7'd32;
        pix_dtype <= dtypei;
        dvo       <= 1'b0;
      end else if (is_start) begin
        ipos   <= '0;
        dvo    <= 1'b1;
        dtypeo <= dtypei;
      end else if (is_hdr) begin
        meta_datao <= datai[15:0];
        hold_hi    <= datai[31:16];
        dvo        <= 1'b1;
        dtypeo     <= `DTYPE_HEADER;
      end else begin
        ipos       <= '0;
        dvo        <= 1'b1;
        dtypeo     <= dtypei;
        meta_datao <= '0;
      end
    end else begin
      dvo <= 1'b0;
    end
  end
endmodule

// File: tb/tb_stream2rgb.sv
// Directed bench for stream2rgb: 10-bit and 8-bit pixel unpacking, header split,
// residual drop, and mid-frame reset.
module tb_stream2rgb;
  localparam logic [7:0] FS  = 8'h01;
  localparam logic [7:0] FE  = 8'h02;
  localparam logic [7:0] HDR = 8'h08;
  localparam logic [7:0] PIX = 8'h10;

  logic        clk = 0, reset = 1;
  logic        dvi = 0, dvi8 = 0;
  logic [7:0]  dtypei = 0, dtypei8 = 0;
  logic [31:0] datai = 0, datai8 = 0;
  logic        rdyo, dvo, rdyo8, dvo8;
  logic [7:0]  dtypeo, dtypeo8;
  logic [9:0]  r, g, b;
  logic [7:0]  r8, g8, b8;
  logic [15:0] meta, meta8;

  int total = 0, passes = 0, stalls = 0;
  logic [53:0] q[$];
  logic [47:0] q8[$];
  logic [29:0] pix[16];
  logic [31:0] w[15];
  logic [479:0] stream;

  always #5 clk = ~clk;

  stream2rgb #(.PIXEL_WIDTH(10)) dut (
    .clk(clk), .reset(reset), .dvi(dvi), .dtypei(dtypei), .datai(datai),
    .rdyo(rdyo), .dvo(dvo), .dtypeo(dtypeo), .r(r), .g(g), .b(b), .meta_datao(meta));

  stream2rgb #(.PIXEL_WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .dvi(dvi8), .dtypei(dtypei8), .datai(datai8),
    .rdyo(rdyo8), .dvo(dvo8), .dtypeo(dtypeo8), .r(r8), .g(g8), .b(b8), .meta_datao(meta8));

  always @(negedge clk) begin
    if (dvo)  q.push_back({dtypeo, meta, r, g, b});
    if (dvo8) q8.push_back({dtypeo8, meta8, r8, g8, b8});
    if (dvi && !rdyo) stalls++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Entered and left at a negedge; dvi stays high so back-to-back calls stream.
  task automatic send(input logic [7:0] dt, input logic [31:0] d);
    int n = 0;
    dvi = 1; dtypei = dt; datai = d;
    while (!rdyo && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) chk("send_timeout", 64'(n), 0);
    @(posedge clk); @(negedge clk);
  endtask

  task automatic send8(input logic [7:0] dt, input logic [31:0] d);
    int n = 0;
    dvi8 = 1; dtypei8 = dt; datai8 = d;
    while (!rdyo8 && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) chk("send8_timeout", 64'(n), 0);
    @(posedge clk); @(negedge clk);
  endtask

  task automatic check_pixels(input int cnt, input string tag);
    logic [53:0] e;
    for (int i = 0; i < cnt; i++) begin
      e = q.pop_front();
      chk($sformatf("%s_dt%0d", tag, i), 64'(e[53:46]), 64'(PIX));
      chk($sformatf("%s_rgb%0d", tag, i), 64'(e[29:0]), 64'(pix[i]));
    end
  endtask

  initial begin
    logic [53:0] e;
    logic [47:0] e8;
    for (int n = 0; n < 16; n++) begin
      pix[n] = {10'(n), 10'(10'h3FF - n), 10'(10'h155 ^ n)};
      stream[479 - 30*n -: 30] = pix[n];
    end
    for (int k = 0; k < 15; k++) w[k] = stream[479 - 32*k -: 32];

    cyc(3);
    reset = 0;
    chk("rst_dvo", 64'(dvo), 0);
    chk("rst_dtypeo", 64'(dtypeo), 0);
    chk("rst_rgb", 64'({r, g, b}), 0);
    chk("rst_meta", 64'(meta), 0);
    chk("rst_rdyo", 64'(rdyo), 1);

    // Full 16-pixel frame with dvi held high throughout
    send(FS, 32'h0);
    for (int k = 0; k < 15; k++) send(PIX, w[k]);
    send(FE, 32'hDEAD_BEEF);
    dvi = 0;
    cyc(3);
    chk("frame_count", 64'(q.size()), 18);
    e = q.pop_front();
    chk("fs_dtype", 64'(e[53:46]), 64'(FS));
    check_pixels(16, "f1");
    e = q.pop_front();
    chk("fe_dtype", 64'(e[53:46]), 64'(FE));
    chk("fe_meta", 64'(e[45:30]), 0);
    chk("stalls_seen", 64'(stalls != 0), 1);

    // Header split across two cycles
    q.delete();
    dvi = 1; dtypei = HDR; datai = 32'h1234_5678;
    @(posedge clk); @(negedge clk);
    dvi = 0;
    chk("hdr_rdyo_low", 64'(rdyo), 0);
    cyc(1);
    chk("hdr_rdyo_back", 64'(rdyo), 1);
    cyc(2);
    chk("hdr_count", 64'(q.size()), 2);
    e = q.pop_front();
    chk("hdr_lo", 64'({e[53:46], e[45:30]}), 64'({HDR, 16'h5678}));
    e = q.pop_front();
    chk("hdr_hi", 64'({e[53:46], e[45:30]}), 64'({HDR, 16'h1234}));

    // Three words then FRAME_START: residual 6 bits dropped
    q.delete();
    for (int k = 0; k < 3; k++) send(PIX, w[k]);
    send(FS, 32'h0);
    dvi = 0;
    cyc(3);
    chk("res_count", 64'(q.size()), 4);
    check_pixels(3, "res");
    e = q.pop_front();
    chk("res_fs", 64'(e[53:46]), 64'(FS));
    chk("res_ipos", 64'(dut.ipos), 0);

    // Reset mid-frame, then a clean frame decodes from bit 0
    q.delete();
    send(FS, 32'h0);
    send(PIX, w[0]);
    send(PIX, w[1]);
    dvi = 0;
    reset = 1;
    cyc(1);
    reset = 0;
    chk("mrst_dvo", 64'(dvo), 0);
    chk("mrst_dtypeo", 64'(dtypeo), 0);
    chk("mrst_rgb", 64'({r, g, b}), 0);
    chk("mrst_meta", 64'(meta), 0);
    chk("mrst_rdyo", 64'(rdyo), 1);
    q.delete();
    for (int k = 0; k < 15; k++) send(PIX, w[k]);
    dvi = 0;
    cyc(4);
    chk("post_rst_count", 64'(q.size()), 16);
    check_pixels(16, "f2");

    // 8-bit pixels: 4 pixels in 3 words
    q8.delete();
    send8(PIX, 32'h1122_3344);
    send8(PIX, 32'h5566_7788);
    send8(PIX, 32'h99AA_BBCC);
    dvi8 = 0;
    cyc(4);
    chk("p8_count", 64'(q8.size()), 4);
    for (int i = 0; i < 4; i++) begin
      e8 = q8.pop_front();
      chk($sformatf("p8_rgb%0d", i), 64'(e8[23:0]),
          64'(i == 0 ? 24'h112233 : i == 1 ? 24'h445566 : i == 2 ? 24'h778899 : 24'hAABBCC));
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
